// File: rtl/image_pkg.sv
// image_pkg: constants and helpers shared by the image line-fetch FIFO
// and the convolution window generator.
//   IMG_WIDTH    - default bits per channel sample
//   IMG_CHANNELS - default channels packed per pixel vector
//   clog2()      - ceiling log2 for sizing pointers and counters
package image_pkg;

  localparam int IMG_WIDTH    = 8;
  localparam int IMG_CHANNELS = 8;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/image_dist_ram_2p.sv
// image_dist_ram_2p: DEPTH x DW two-port distributed RAM.
// The write port is synchronous. The read port is asynchronous, which gives
// the FIFO its first-word-fall-through head. The contents are not reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data at raddr
module image_dist_ram_2p #(
  parameter int DW        = 64,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DW-1:0]        wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DW-1:0]        rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  (* ram_style = "distributed" *) logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/image_chan_fifo.sv
// image_chan_fifo: multi-channel first-word-fall-through FIFO.
// Each entry holds one pixel vector, with channel c at bits [c*WIDTH +: WIDTH].
// The FIFO uses valid/ready handshakes on both sides.
//   clk, rst_n  - clock and asynchronous active-low reset
//   flush       - synchronous clear; wins over a push or pop in the same cycle
//   s_valid/s_ready/s_data - write side (s_ready is registered)
//   m_valid/m_ready/m_data - read side (m_valid is registered,
//                            m_data is read directly from the RAM)
//   count       - occupancy 0..DEPTH
//   almost_full - registered, high when count >= AFULL_THRESH
module image_chan_fifo
  import image_pkg::*;
#(
  parameter int WIDTH        = IMG_WIDTH,
  parameter int CHANNELS     = IMG_CHANNELS,
  parameter int ADDR_BITS    = 5,
  parameter int AFULL_THRESH = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH*CHANNELS-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH*CHANNELS-1:0] m_data,
  output logic [ADDR_BITS:0]        count,
  output logic                      almost_full
);

  localparam int DW    = WIDTH * CHANNELS;
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = ADDR_BITS + 1;

  localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]        AFULL_C = CW'(AFULL_THRESH);
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [CW-1:0]        next_count;
  logic                 push;
  logic                 pop;

  // A flush cycle must not write the RAM, so flush also gates the write enable.
  assign push = s_valid & s_ready & ~flush;
  assign pop  = m_valid & m_ready;

  always_comb begin
    next_count = count;
    unique case ({push, pop})
      2'b10:   next_count = count + CNT_ONE;
      2'b01:   next_count = count - CNT_ONE;
      default: next_count = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      m_valid     <= 1'b0;
      almost_full <= 1'b0;
      s_ready     <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      m_valid     <= 1'b0;
      almost_full <= 1'b0;
      s_ready     <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count       <= next_count;
      // The flags are registered from next_count, so they already reflect
      // this edge's transfers right after the edge.
      s_ready     <= (next_count != DEPTH_C);
      m_valid     <= (next_count != '0);
      almost_full <= (next_count >= AFULL_C);
    end
  end

  image_dist_ram_2p #(
    .DW        (DW),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (s_data),
    .raddr (rd_ptr),
    .rdata (m_data)
  );

endmodule

// File: doc/image_chan_fifo.md
# image_chan_fifo

Parametrised multi-channel FIFO on distributed RAM with valid/ready handshakes on both sides, first-word-fall-through read, occupancy count, almost-full flag and synchronous flush. Sits between the image line-fetch stage and the convolution window generator. Buffers one pixel vector (all channels of one pixel) per entry, so producer and consumer can stall independently.

## Interface
- WIDTH, 8, bits per channel sample
- CHANNELS, 8, channels packed per entry; data width DW = WIDTH*CHANNELS, channel c at bits [c*WIDTH +: WIDTH]
- ADDR_BITS, 5, pointer width; DEPTH = 2**ADDR_BITS entries
- AFULL_THRESH, 24, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all contents
- s_valid  in  1  write request
- s_ready  out  1  FIFO can accept; registered
- s_data  in  DW  write vector
- m_valid  out  1  head entry present; registered
- m_ready  in  1  consumer takes head
- m_data  out  DW  head entry, valid whenever m_valid=1
- count  out  ADDR_BITS+1  occupancy 0..DEPTH; registered
- almost_full  out  1  count >= AFULL_THRESH; registered

## Operation
- push = s_valid & s_ready; pop = m_valid & m_ready.
- Push writes s_data to ram[wr_ptr], wr_ptr+1 mod DEPTH. Pop advances rd_ptr+1 mod DEPTH. Pointers wrap naturally at 2**ADDR_BITS.
- m_data = ram[rd_ptr], asynchronous read; no output register.
- next_count = count + push - pop; push and pop same cycle leaves count unchanged and both succeed.
- s_ready, m_valid, almost_full are registered from next_count: s_ready <= next_count != DEPTH; m_valid <= next_count != 0; almost_full <= next_count >= AFULL_THRESH.
- Full (count=DEPTH): s_ready=0, push impossible; a pop that cycle raises s_ready next cycle.
- Empty (count=0): m_valid=0, pop impossible; push into empty FIFO is not visible on m_* until next cycle (no bypass).
- flush=1: next cycle pointers=0, count=0, m_valid=0, almost_full=0, s_ready=1. Flush overrides push/pop that same cycle; data offered that cycle is dropped and not written; m_data ignored.
- s_valid/s_data held stable by producer until accepted; FIFO never drops an accepted entry except via flush/reset.
- RAM contents not reset; only pointers and flags.

## Timing
- Reset (rst_n=0, asynchronous): wr_ptr=rd_ptr=0, count=0, m_valid=0, almost_full=0, s_ready=0. First edge with rst_n=1 sets s_ready=1.
- Reset asserted mid-transfer: all state cleared immediately; in-flight entries lost.
- Write-to-read latency: push at edge N -> m_valid=1, m_data valid after edge N (1 cycle).
- Full throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Flag latency: count, s_ready, m_valid, almost_full all reflect transfers of edge N immediately after edge N.

## Structure
- Shared package image_pkg: function for clog2 where needed, and default WIDTH/CHANNELS constants shared with the window generator.
- One sub-module: image_dist_ram_2p, (* ram_style="distributed" *) array of DEPTH x DW, synchronous write port, asynchronous read port; no reset.
- Top holds pointers, count and registered flags.

## Test plan
- Reset: rst_n low 3 cycles then high -> during reset s_ready=0, m_valid=0, count=0; one edge later s_ready=1.
- Fill: DEPTH=32, push 32 vectors 0x00..0x1F in all channels, m_ready=0 -> count=32, s_ready=0 after 32nd push, almost_full=1 from count=24.
- Drain order: after fill, m_ready=1 for 32 cycles -> m_data sequence 0x00..0x1F in order, m_valid=0 and count=0 after last pop.
- Simultaneous at boundary: count=32, s_valid=1 and m_ready=1 -> pop only that cycle, count=31, s_ready=1 next cycle, following push accepted; pointer wrap verified by 100 random-stall transfers matching a reference queue.
- Flush: count=10 with s_valid=1 and m_ready=1 in flush cycle -> next cycle count=0, m_valid=0, s_ready=1; offered vector never appears at m_data.
- Channel packing: CHANNELS=4, WIDTH=8, push 0xDDCCBBAA -> m_data channel 0=0xAA, channel 3=0xDD one cycle later.
